// File: rtl/fre_div_pkg.sv
// Shared types and helpers for the programmable clock-enable divider.
package fre_div_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  localparam int DEF_LOW_C  = 2;
  localparam int DEF_HIGH_C = 3;

  // A programmed length of 0 still produces a one-cycle phase.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/fre_divn_prog_if.sv
// Configuration handshake between a timing master and the divider.
interface fre_divn_prog_if #(parameter int WIDTH = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_low;
  logic [WIDTH-1:0] cfg_high;

  modport master (output cfg_valid, cfg_low, cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, cfg_low, cfg_high, output cfg_ready);
endinterface

// File: rtl/fre_div_shadow.sv
// One-deep shadow register: holds an accepted configuration until the
// divider signals a safe point to apply it.
module fre_div_shadow #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  fre_divn_prog_if.slave   cfg,
  input  logic             apply,
  output logic             pending,
  output logic [WIDTH-1:0] pend_low,
  output logic [WIDTH-1:0] pend_high
);

  assign cfg.cfg_ready = !pending;

  // Accept and apply are mutually exclusive: accept needs an empty slot,
  // apply only fires when the slot is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_low  <= '0;
      pend_high <= '0;
    end else if (apply) begin
      pending <= 1'b0;
    end else if (cfg.cfg_valid && !pending) begin
      pending   <= 1'b1;
      pend_low  <= cfg.cfg_low;
      pend_high <= cfg.cfg_high;
    end
  end

endmodule

// File: rtl/fre_divn_prog.sv
// Programmable low/high clock-enable divider with run enable, period tick
// and boundary-aligned reconfiguration.
module fre_divn_prog
  import fre_div_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEF_LOW  = DEF_LOW_C,
  parameter int DEF_HIGH = DEF_HIGH_C
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  fre_divn_prog_if.slave cfg,
  output logic           div_out,
  output logic           tick,
  output logic           busy
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] act_low, act_high;
  logic [WIDTH-1:0] low_last, high_last;
  logic [WIDTH-1:0] pend_low, pend_high;
  logic             pending, apply;

  fre_div_shadow #(.WIDTH(WIDTH)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg),
    .apply     (apply),
    .pending   (pending),
    .pend_low  (pend_low),
    .pend_high (pend_high)
  );

  assign low_last  = WIDTH'(eff_len(32'(act_low))  - 32'd1);
  assign high_last = WIDTH'(eff_len(32'(act_high)) - 32'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        apply = pending;
        if (en) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == low_last) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == high_last) begin
          // Period boundary: the only in-run point where L/H may change.
          state_nxt = LOW;
          cnt_nxt   = '0;
          apply     = pending;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      act_low  <= WIDTH'(DEF_LOW);
      act_high <= WIDTH'(DEF_HIGH);
      div_out  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Outputs are decoded from next state so they leave flops directly.
      div_out <= (state_nxt == HIGH);
      tick    <= (state == LOW) && (state_nxt == HIGH);
      busy    <= (state_nxt != IDLE);
      if (apply) begin
        act_low  <= pend_low;
        act_high <= pend_high;
      end
    end
  end

endmodule
